gnr_attractor_ctrl: RTL and testbench
=====================================

Name: gnr_attractor_ctrl

Overview:
- Upstream controller and downstream consumer for a bank of GRN node instances (s0 = slow/tortoise trajectory, s1 = fast/hare trajectory).
- Per run it does four things:
  - accepts an initial network state;
  - loads it into all nodes via reset_nos/init_state;
  - steps the nodes with start_s0/start_s1 until the two trajectories meet (Floyd cycle detection);
  - measures the attractor period and returns meet step, period and attractor state through a valid/ready result port.

Parameters:
- N_NODES, 8, number of GRN nodes; width of state vectors.
- CNT_W, 16, width of the step and period counters.
- MAX_STEPS, 16'hFFFF, step limit; used only with GNR_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_valid  in  1  initial-state offer
- init_ready  out  1  controller idle, accepts init_state_in
- init_state_in  in  N_NODES  initial state, one bit per node
- reset_nos  out  N_NODES  per-node load strobe (all bits identical)
- init_state  out  N_NODES  per-node load value, registered
- start_s0  out  N_NODES  slow-trajectory step enable (all bits identical)
- start_s1  out  N_NODES  fast-trajectory step enable (all bits identical)
- s0_vec  in  N_NODES  concatenated node s0 outputs
- s1_vec  in  N_NODES  concatenated node s1 outputs
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_meet  out  CNT_W  RUN cycle count c at meet
- res_period  out  CNT_W  attractor period (≥1)
- res_state  out  N_NODES  s1_vec at period detection
- res_timeout  out  1  run aborted by step limit

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE;
  - all counters and result registers clear to 0;
  - res_valid=0, reset_nos=0, start_s0=start_s1=0, init_state=0.
  - rst_n low mid-run abandons the run; no partial result is ever produced.
- IDLE:
  - init_ready=1.
  - On init_valid, register init_state_in into init_state and go to LOAD.
- LOAD (exactly 1 cycle):
  - reset_nos=all ones; start_s0=start_s1=0.
  - Clear step counter c=0, then go to RUN.
- RUN: step counting and timing.
  - Each RUN cycle, c increments.
  - Nodes are registered, so the inputs in cycle c reflect the c step pulses already issued.
  - Node s0 updates on every second start_s0 pulse, beginning with the first. At even c, s0_vec = x(c/2) and s1_vec = x(c).
- RUN: meet detection.
  - match = (s0_vec == s1_vec), evaluated combinationally.
  - Meet = match && c ≥ 2 && c even.
- RUN: step gating.
  - start_s0 = start_s1 = all ones in every RUN cycle except the meet cycle.
  - Gating is combinational from the FSM state and meet. No pulse is issued in the meet cycle.
- RUN: on meet.
  - Latch res_meet=c.
  - Clear period counter p=0, then go to PERIOD.
- PERIOD: stepping.
  - start_s0=0 holds the tortoise; start_s1=all ones advances the hare. p increments each cycle.
  - At cycle p (p ≥ 1), s1_vec = x(c+p).
- PERIOD: detection.
  - When p ≥ 1 and s1_vec == s0_vec: latch res_period=p and res_state=s1_vec.
  - No pulse is issued in that cycle. Go to DONE.
- Fixed point: a fixed point yields res_period=1.
- DONE:
  - res_valid=1. Result registers are stable while res_valid=1.
  - On res_valid && res_ready, go to IDLE (init_ready rises the next cycle).
  - A new init is never accepted while in DONE.
- Boundary conditions:
  - init_valid during LOAD/RUN/PERIOD/DONE is ignored (init_ready=0).
  - A match at odd c, or at c=0, is not a meet.
- Counters: c and p saturate at 2^CNT_W-1 and do not wrap. Without GNR_TIMEOUT_EN, saturation is the only protection against non-termination.

Optional Feature:
- Macro: GNR_TIMEOUT_EN.
- With the macro:
  - If c reaches MAX_STEPS in RUN, or p reaches MAX_STEPS in PERIOD, the FSM goes to DONE with res_timeout=1.
  - In that case res_period=0, and res_meet holds its latched value (0 if the limit was hit in RUN).
- Without the macro: res_timeout is tied to 0, and the run continues until detection.

Decomposition:
- Shared package gnr_pkg holds:
  - FSM state enum (IDLE, LOAD, RUN, PERIOD, DONE);
  - default N_NODES and CNT_W;
  - saturating-increment helper function.
- One natural sub-module, gnr_sat_counter (CNT_W, clear, enable, saturate). It is instantiated twice, for c and p.

Test Plan:
- Fixed point: init 8'h00, node functions are identity → res_meet=2, res_period=1, res_state=8'h00, res_timeout=0.
- 3-cycle rotator: nodes rotate the state left, init 8'h01 with N=3 wrap → meet at c=6, res_period=3, res_state=x(9).
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → outputs stable, init_ready=0, init_valid ignored. Then res_ready=1 → IDLE next cycle.
- Async reset mid-PERIOD: drop rst_n → all outputs 0 immediately. After release, the next init produces a clean, correct result.
- Odd-c false match: stimulus where s0==s1 at c=3 only → no meet at c=3, detection continues to the correct even c.
- GNR_TIMEOUT_EN, MAX_STEPS=20: long-transient network → res_timeout=1 at c=20, res_period=0.

Source files
------------

// File: rtl/gnr_pkg.sv
// Shared definitions for the GRN attractor controller: FSM encodings, default sizes and
// a saturating-increment helper.
package gnr_pkg;

    localparam int unsigned GNR_N_NODES = 8;
    localparam int unsigned GNR_CNT_W   = 16;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StPeriod = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/gnr_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module gnr_sat_counter
    import gnr_pkg::*;
#(
    parameter int unsigned CNT_W = GNR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] MaxCount = 32'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = CNT_W'(sat_inc(32'(count_q), MaxCount));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection controller for a bank of GRN nodes (s0 = tortoise, s1 = hare).
// Optional step limit enabled by defining GNR_TIMEOUT_EN.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int unsigned N_NODES   = GNR_N_NODES,
    parameter int unsigned CNT_W     = GNR_CNT_W,
    parameter int unsigned MAX_STEPS = 32'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_state_in,
    output logic [N_NODES-1:0] reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic [N_NODES-1:0] start_s0,
    output logic [N_NODES-1:0] start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic [N_NODES-1:0] res_state,
    output logic               res_timeout
);

    logic [2:0]         state_q, state_d;
    logic [N_NODES-1:0] init_state_q;
    logic [CNT_W-1:0]   res_meet_q, res_period_q;
    logic [N_NODES-1:0] res_state_q;
    logic [CNT_W-1:0]   c_cnt, p_cnt;

    logic in_idle, in_load, in_run, in_period, in_done;
    logic match, meet, period_hit, run_timeout, period_timeout;
    logic run_step, period_step;

    assign in_idle   = (state_q == StIdle);
    assign in_load   = (state_q == StLoad);
    assign in_run    = (state_q == StRun);
    assign in_period = (state_q == StPeriod);
    assign in_done   = (state_q == StDone);

    assign match      = (s0_vec == s1_vec);
    // Only even c compares x(c/2) against x(c); c = 0 is the trivial start-point match.
    assign meet       = in_run && match && (c_cnt >= CNT_W'(2)) && !c_cnt[0];
    assign period_hit = in_period && match && (p_cnt != '0);

`ifdef GNR_TIMEOUT_EN
    logic res_timeout_q;

    assign run_timeout    = in_run && !meet && (32'(c_cnt) >= MAX_STEPS);
    assign period_timeout = in_period && !period_hit && (32'(p_cnt) >= MAX_STEPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_timeout_q <= 1'b0;
        end else if (in_load) begin
            res_timeout_q <= 1'b0;
        end else if (run_timeout || period_timeout) begin
            res_timeout_q <= 1'b1;
        end
    end

    assign res_timeout = res_timeout_q;
`else
    logic unused_max_steps;

    assign run_timeout      = 1'b0;
    assign period_timeout   = 1'b0;
    assign unused_max_steps = ^MAX_STEPS;
    assign res_timeout      = 1'b0;
`endif

    // No pulse in the cycle that ends a phase, so the trajectories stay where they matched.
    assign run_step    = in_run && !meet && !run_timeout;
    assign period_step = in_period && !period_hit && !period_timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (init_valid) state_d = StLoad;
            StLoad:   state_d = StRun;
            StRun: begin
                if (meet) begin
                    state_d = StPeriod;
                end else if (run_timeout) begin
                    state_d = StDone;
                end
            end
            StPeriod: if (period_hit || period_timeout) state_d = StDone;
            StDone:   if (res_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            init_state_q <= '0;
            res_meet_q   <= '0;
            res_period_q <= '0;
            res_state_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_idle && init_valid) begin
                init_state_q <= init_state_in;
            end
            if (in_load) begin
                res_meet_q   <= '0;
                res_period_q <= '0;
                res_state_q  <= '0;
            end
            if (meet) begin
                res_meet_q <= c_cnt;
            end
            if (period_hit) begin
                res_period_q <= p_cnt;
                res_state_q  <= s1_vec;
            end
        end
    end

    gnr_sat_counter #(
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (in_load),
        .enable (in_run),
        .count  (c_cnt)
    );

    gnr_sat_counter #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (meet),
        .enable (in_period),
        .count  (p_cnt)
    );

    assign init_ready = in_idle;
    assign reset_nos  = {N_NODES{in_load}};
    assign init_state = init_state_q;
    assign start_s0   = {N_NODES{run_step}};
    assign start_s1   = {N_NODES{run_step || period_step}};
    assign res_valid  = in_done;
    assign res_meet   = res_meet_q;
    assign res_period = res_period_q;
    assign res_state  = res_state_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: behavioural node bank plus a Floyd reference model feeding
// a result scoreboard. Honours GNR_TIMEOUT_EN (step limit 20 when defined).
module tb_gnr_attractor_ctrl;

`ifdef GNR_TIMEOUT_EN
    localparam int unsigned TbMaxSteps = 20;
    localparam bit          TimeoutEn  = 1'b1;
`else
    localparam int unsigned TbMaxSteps = 32'hFFFF;
    localparam bit          TimeoutEn  = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] meet;
        logic [15:0] period;
        logic [7:0]  state;
        logic        timeout;
    } exp_t;

    logic        clk, rst_n;
    logic        init_valid, init_ready;
    logic [7:0]  init_state_in, reset_nos, init_state, start_s0, start_s1, s0_vec, s1_vec;
    logic        res_valid, res_ready, res_timeout;
    logic [15:0] res_meet, res_period;
    logic [7:0]  res_state;

    int   vectors = 0;
    int   miscompares = 0;
    int   node_mode = 0;
    logic [7:0] last_init = '0;
    exp_t sb[$];

    gnr_attractor_ctrl #(
        .N_NODES   (8),
        .CNT_W     (16),
        .MAX_STEPS (TbMaxSteps)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_valid    (init_valid),
        .init_ready    (init_ready),
        .init_state_in (init_state_in),
        .reset_nos     (reset_nos),
        .init_state    (init_state),
        .start_s0      (start_s0),
        .start_s1      (start_s1),
        .s0_vec        (s0_vec),
        .s1_vec        (s1_vec),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_meet      (res_meet),
        .res_period    (res_period),
        .res_state     (res_state),
        .res_timeout   (res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network update functions selected per test.
    function automatic logic [7:0] node_f(input int mode, input logic [7:0] x);
        case (mode)
            0:       return x;
            1:       return {x[7:3], x[1:0], x[2]};
            2:       return (x < 8'd2) ? x + 8'd1 : x;
            3:       return (x == 8'd9) ? 8'd5 : x + 8'd1;
            default: return (x < 8'd200) ? x + 8'd1 : x;
        endcase
    endfunction

    // Node bank: s0 advances on the 1st, 3rd, 5th... start_s0 pulse, s1 on every pulse.
    logic [7:0] n_s0, n_s1;
    logic       s0_phase;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_s0 <= '0; n_s1 <= '0; s0_phase <= 1'b0;
        end else if (reset_nos[0]) begin
            n_s0 <= init_state; n_s1 <= init_state; s0_phase <= 1'b0;
        end else begin
            if (start_s1[0]) n_s1 <= node_f(node_mode, n_s1);
            if (start_s0[0]) begin
                if (!s0_phase) n_s0 <= node_f(node_mode, n_s0);
                s0_phase <= ~s0_phase;
            end
        end
    end
    assign s0_vec = n_s0;
    assign s1_vec = n_s1;

    function automatic logic [7:0] xk(input int mode, input logic [7:0] init, input int k);
        logic [7:0] x;
        x = init;
        for (int i = 0; i < k; i++) x = node_f(mode, x);
        return x;
    endfunction

    // Floyd on the ideal trajectory: smallest even c>=2 with x(c/2)==x(c), then the
    // smallest p>=1 with x(c+p)==x(c/2).
    function automatic exp_t ref_result(input int mode, input logic [7:0] init);
        exp_t r;
        int c, p;
        logic [7:0] t;
        r = '0;
        c = 2;
        while (c < 4000 && xk(mode, init, c / 2) != xk(mode, init, c)) c += 2;
        if (TimeoutEn && c > int'(TbMaxSteps)) begin
            r.timeout = 1'b1;
            return r;
        end
        r.meet = 16'(c);
        t = xk(mode, init, c / 2);
        p = 1;
        while (p < 4000 && xk(mode, init, c + p) != t) p++;
        if (TimeoutEn && p > int'(TbMaxSteps)) begin
            r.timeout = 1'b1;
            return r;
        end
        r.period = 16'(p);
        r.state  = xk(mode, init, c + p);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int mode, input logic [7:0] init);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        node_mode     = mode;
        init_state_in = init;
        init_valid    = 1'b1;
        last_init     = init;
        for (int i = 0; i < 50; i++) begin
            if (init_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("init_accept", 32'(ok), 32'd1);
        @(negedge clk);
        init_valid = 1'b0;
        check("load_reset_nos", 32'(reset_nos), 32'hFF);
        check("load_start_s0", 32'(start_s0), 32'h0);
        check("load_start_s1", 32'(start_s1), 32'h0);
        check("load_init_ready", 32'(init_ready), 32'd0);
        check("load_init_state", 32'(init_state), 32'(init));
        sb.push_back(ref_result(mode, init));
    endtask

    task automatic finish_run(input int budget, input int hold);
        bit   got;
        exp_t e;
        got = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("res_valid_wait", 32'(got), 32'd1);
        e = sb.pop_front();
        if (!got) return;
        check("res_meet", 32'(res_meet), 32'(e.meet));
        check("res_period", 32'(res_period), 32'(e.period));
        check("res_state", 32'(res_state), 32'(e.state));
        check("res_timeout", 32'(res_timeout), 32'(e.timeout));
        if (hold > 0) begin
            init_valid    = 1'b1;
            init_state_in = last_init ^ 8'hA5;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_res_valid", 32'(res_valid), 32'd1);
                check("hold_init_ready", 32'(init_ready), 32'd0);
                check("hold_res_meet", 32'(res_meet), 32'(e.meet));
                check("hold_res_period", 32'(res_period), 32'(e.period));
                check("hold_res_state", 32'(res_state), 32'(e.state));
                check("hold_init_state", 32'(init_state), 32'(last_init));
            end
            init_valid    = 1'b0;
            init_state_in = last_init;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_res_valid", 32'(res_valid), 32'd0);
        check("post_init_ready", 32'(init_ready), 32'd1);
        check("post_init_state", 32'(init_state), 32'(last_init));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_reset_nos"}, 32'(reset_nos), 32'd0);
        check({tag, "_start_s0"}, 32'(start_s0), 32'd0);
        check({tag, "_start_s1"}, 32'(start_s1), 32'd0);
        check({tag, "_init_state"}, 32'(init_state), 32'd0);
        check({tag, "_res_meet"}, 32'(res_meet), 32'd0);
        check({tag, "_res_period"}, 32'(res_period), 32'd0);
        check({tag, "_res_state"}, 32'(res_state), 32'd0);
        check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        init_valid    = 1'b0;
        init_state_in = '0;
        res_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_init_ready", 32'(init_ready), 32'd1);

        // Fixed point: identity network.
        start_run(0, 8'h00);
        finish_run(100, 0);

        // 3-cycle rotator with result backpressure.
        start_run(1, 8'h01);
        finish_run(100, 10);

        // Asynchronous reset while in PERIOD (meet at c=6, so PERIOD after 8 negedges).
        start_run(1, 8'h01);
        repeat (9) @(negedge clk);
        check("period_start_s0", 32'(start_s0), 32'h0);
        check("period_start_s1", 32'(start_s1), 32'hFF);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        start_run(1, 8'h01);
        finish_run(100, 0);

        // Matches at odd c only before the true meet.
        start_run(2, 8'h00);
        finish_run(100, 0);

        // Transient of 5 into a 5-cycle.
        start_run(3, 8'h00);
        finish_run(200, 0);

        // Long transient: step limit when enabled, late meet otherwise.
        start_run(4, 8'h00);
        finish_run(1000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
